// File: rtl/ma_pkg.sv
// Shared types and constants for the memory-access responder.
package ma_pkg;

  typedef enum logic [1:0] {
    LDUMP = 2'd0,
    SDUMP = 2'd1,
    FREE  = 2'd2,
    SPAWN = 2'd3
  } ma_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } ma_state_t;

  localparam logic [15:0] MA_ERR = 16'hFFFF;

endpackage

// File: rtl/ma_responder_if.sv
// ID-stage ma_request bus: one request per cycle, answered combinationally.
interface ma_responder_if import ma_pkg::*;;

  logic        ma_request;
  ma_op_t      ma_op;
  logic [15:0] ma_where;
  logic [15:0] ma_what;
  logic [15:0] ma_count;
  logic [15:0] ma_answer;

  modport master (
    output ma_request, ma_op, ma_where, ma_what, ma_count,
    input  ma_answer
  );

  modport slave (
    input  ma_request, ma_op, ma_where, ma_what, ma_count,
    output ma_answer
  );

endinterface

// File: rtl/ma_responder_pid_table.sv
// Process-slot table: used bitmap, lowest-free encoder, alloc/free strobes.
module pid_table #(
  parameter int unsigned NPROC = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        alloc,
  input  logic        free_req,
  input  logic [15:0] free_pid,
  output logic [3:0]  lowest_free,
  output logic        full,
  output logic        free_err
);

  logic [NPROC-1:0] used_q, used_d;
  logic [15:0]      used_pad, next_pad;

  // Zero-padded view so any 4-bit pid index stays in range for NPROC < 16
  assign used_pad = 16'(used_q);
  assign full     = &used_q;

  // Lowest free slot: scan downwards so the smallest index wins
  always_comb begin
    lowest_free = '0;
    for (int unsigned i = NPROC; i > 0; i--) begin
      if (!used_q[i-1]) lowest_free = 4'(i - 1);
    end
  end

  // Reject out-of-range pids, the boot process and slots that are already free
  always_comb begin
    free_err = (free_pid >= 16'(NPROC)) || (free_pid == '0) || !used_pad[free_pid[3:0]];
  end

  // Next bitmap from the alloc/free strobes
  always_comb begin
    next_pad = used_pad;
    if (alloc && !full)        next_pad[lowest_free]   = 1'b1;
    if (free_req && !free_err) next_pad[free_pid[3:0]] = 1'b0;
    used_d = next_pad[NPROC-1:0];
  end

  // Bitmap register; reset leaves only the boot slot in use
  always_ff @(posedge clk) begin
    if (clr) used_q <= NPROC'(1);
    else     used_q <= used_d;
  end

endmodule

// File: rtl/ma_responder.sv
// MA responder: combinational answers, background dump DMA, pid slot table.
module ma_responder import ma_pkg::*; #(
  parameter int unsigned NPROC = 16,
  parameter int unsigned AW    = 16
) (
  input  logic          clk,
  input  logic          clr,
  ma_responder_if.slave ma,
  output logic          dma_busy,
  output logic          dma_done,
  output logic [AW-1:0] lm_addr,
  output logic [15:0]   lm_wdata,
  output logic          lm_we,
  input  logic [15:0]   lm_rdata,
  output logic [AW-1:0] sm_addr,
  output logic [15:0]   sm_wdata,
  output logic          sm_we,
  input  logic [15:0]   sm_rdata
);

  ma_state_t     state_q, state_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d;
  logic [15:0]   rem_q, rem_d;
  logic          from_lm_q, from_lm_d;

  logic          busy, is_dump, dump_go, spawn_req, free_req;
  logic [3:0]    lowest_free;
  logic          full, free_err;

  assign busy      = (state_q != IDLE);
  assign is_dump   = (ma.ma_op == LDUMP) || (ma.ma_op == SDUMP);
  assign dump_go   = ma.ma_request && is_dump && !busy && (ma.ma_count != '0);
  assign spawn_req = ma.ma_request && (ma.ma_op == SPAWN);
  assign free_req  = ma.ma_request && (ma.ma_op == FREE);

  pid_table #(.NPROC(NPROC)) u_pid_table (
    .clk         (clk),
    .clr         (clr),
    .alloc       (spawn_req),
    .free_req    (free_req),
    .free_pid    (ma.ma_what),
    .lowest_free (lowest_free),
    .full        (full),
    .free_err    (free_err)
  );

  // Answer mux, valid only in the request cycle
  always_comb begin
    ma.ma_answer = '0;
    if (ma.ma_request) begin
      unique case (ma.ma_op)
        LDUMP, SDUMP: ma.ma_answer = busy ? MA_ERR : ma.ma_count;
        SPAWN:        ma.ma_answer = full ? MA_ERR : 16'(lowest_free);
        FREE:         ma.ma_answer = free_err ? MA_ERR : '0;
        default:      ma.ma_answer = '0;
      endcase
    end
  end

  // DMA sequencer: one read cycle then one write cycle per word
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    from_lm_d = from_lm_q;
    unique case (state_q)
      IDLE: begin
        if (dump_go) begin
          src_d     = AW'(ma.ma_what);
          dst_d     = AW'(ma.ma_where);
          rem_d     = ma.ma_count;
          from_lm_d = (ma.ma_op == SDUMP);
          state_d   = RD;
        end
      end
      RD: state_d = WR;
      WR: begin
        src_d   = src_q + 1'b1;
        dst_d   = dst_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        state_d = (rem_q > 16'd1) ? RD : DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory port drive; write enable is masked by clr so an aborted word never lands
  always_comb begin
    lm_addr  = '0;
    lm_wdata = '0;
    lm_we    = 1'b0;
    sm_addr  = '0;
    sm_wdata = '0;
    sm_we    = 1'b0;
    dma_busy = busy;
    dma_done = (state_q == DONE);
    if (state_q == RD) begin
      if (from_lm_q) lm_addr = src_q;
      else           sm_addr = src_q;
    end else if (state_q == WR) begin
      if (from_lm_q) begin
        sm_addr  = dst_q;
        sm_wdata = lm_rdata;
        sm_we    = !clr;
      end else begin
        lm_addr  = dst_q;
        lm_wdata = sm_rdata;
        lm_we    = !clr;
      end
    end
  end

  // DMA state registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      from_lm_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      from_lm_q <= from_lm_d;
    end
  end

endmodule

// File: tb/tb_ma_responder.sv
// Scoreboard bench for ma_responder: answer and memory-write queues checked by a monitor.
module tb_ma_responder;
  import ma_pkg::*;

  localparam int unsigned NPROC = 16;
  localparam int unsigned AW    = 16;

  logic          clk = 1'b0;
  logic          clr;
  logic          dma_busy, dma_done;
  logic [AW-1:0] lm_addr, sm_addr;
  logic [15:0]   lm_wdata, sm_wdata, lm_rdata, sm_rdata;
  logic          lm_we, sm_we;

  ma_responder_if bus ();

  ma_responder #(.NPROC(NPROC), .AW(AW)) dut (
    .clk      (clk),
    .clr      (clr),
    .ma       (bus),
    .dma_busy (dma_busy),
    .dma_done (dma_done),
    .lm_addr  (lm_addr),
    .lm_wdata (lm_wdata),
    .lm_we    (lm_we),
    .lm_rdata (lm_rdata),
    .sm_addr  (sm_addr),
    .sm_wdata (sm_wdata),
    .sm_we    (sm_we),
    .sm_rdata (sm_rdata)
  );

  always #5 clk = ~clk;

  // Memory models with a preload port so the arrays have a single writer
  logic [15:0] lm_mem [0:65535];
  logic [15:0] sm_mem [0:65535];
  logic        pre_we, pre_sm;
  logic [15:0] pre_addr, pre_data;

  always @(posedge clk) begin
    lm_rdata <= lm_mem[lm_addr];
    sm_rdata <= sm_mem[sm_addr];
    if (pre_we) begin
      if (pre_sm) sm_mem[pre_addr] <= pre_data;
      else        lm_mem[pre_addr] <= pre_data;
    end else begin
      if (lm_we) lm_mem[lm_addr] <= lm_wdata;
      if (sm_we) sm_mem[sm_addr] <= sm_wdata;
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_sm;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic [15:0] exp_ans [$];
  wr_t         exp_wr  [$];
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          done_count = 0;
  int unsigned done_cyc  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: answers in request cycles, every memory write, and dma_done pulses
  always @(negedge clk) begin
    if (bus.ma_request) begin
      total_cnt++;
      if (exp_ans.size() == 0) begin
        $display("FAIL answer: got %0h with no expected value queued", bus.ma_answer);
      end else begin
        logic [15:0] e;
        e = exp_ans.pop_front();
        if (bus.ma_answer === e) pass_cnt++;
        else $display("FAIL answer: got %0h expected %0h", bus.ma_answer, e);
      end
    end
    for (int k = 0; k < 2; k++) begin
      logic        we, sm;
      logic [15:0] a, d;
      sm = (k == 1);
      we = sm ? sm_we : lm_we;
      a  = sm ? sm_addr : lm_addr;
      d  = sm ? sm_wdata : lm_wdata;
      if (we) begin
        total_cnt++;
        if (exp_wr.size() == 0) begin
          $display("FAIL write: unexpected %s write addr %0h data %0h", sm ? "sm" : "lm", a, d);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          if (w.is_sm === sm && w.addr === a && w.data === d) pass_cnt++;
          else $display("FAIL write: got sm=%0b addr %0h data %0h expected sm=%0b addr %0h data %0h",
                        sm, a, d, w.is_sm, w.addr, w.data);
        end
      end
    end
    if (dma_done) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  task automatic preload(input logic sm, input logic [15:0] addr, input logic [15:0] data);
    pre_we = 1'b1; pre_sm = sm; pre_addr = addr; pre_data = data;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic expect_wr(input logic sm, input logic [15:0] addr, input logic [15:0] data);
    wr_t w;
    w.is_sm = sm; w.addr = addr; w.data = data;
    exp_wr.push_back(w);
  endtask

  // Drive one request cycle; caller sits just after a rising edge
  task automatic issue(input ma_op_t op, input logic [15:0] where, input logic [15:0] what,
                       input logic [15:0] count, input logic [15:0] exp);
    bus.ma_request = 1'b1;
    bus.ma_op      = op;
    bus.ma_where   = where;
    bus.ma_what    = what;
    bus.ma_count   = count;
    exp_ans.push_back(exp);
    @(posedge clk); #1;
    bus.ma_request = 1'b0;
  endtask

  task automatic wait_done(input int start_count);
    int n;
    n = 0;
    while (done_count == start_count && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("dma_done_seen", 32'(done_count - start_count), 32'd1);
  endtask

  int unsigned t0;
  int          dc;

  initial begin
    clr = 1'b1;
    pre_we = 1'b0; pre_sm = 1'b0; pre_addr = '0; pre_data = '0;
    bus.ma_request = 1'b0; bus.ma_op = LDUMP;
    bus.ma_where = '0; bus.ma_what = '0; bus.ma_count = '0;
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check("rst_ctrl",   {28'd0, dma_busy, dma_done, lm_we, sm_we}, 32'd0);
    check("rst_addr",   {lm_addr, sm_addr}, 32'd0);
    check("rst_data",   {lm_wdata, sm_wdata}, 32'd0);
    check("rst_answer", {16'd0, bus.ma_answer}, 32'd0);
    @(posedge clk); #1;

    // SDUMP of three words, with an LDUMP bounced while busy
    preload(1'b0, 16'h0020, 16'hAAAA);
    preload(1'b0, 16'h0021, 16'hBBBB);
    preload(1'b0, 16'h0022, 16'hCCCC);
    expect_wr(1'b1, 16'h0100, 16'hAAAA);
    expect_wr(1'b1, 16'h0101, 16'hBBBB);
    expect_wr(1'b1, 16'h0102, 16'hCCCC);
    dc = done_count;
    t0 = cyc;
    issue(SDUMP, 16'h0100, 16'h0020, 16'd3, 16'd3);
    issue(LDUMP, 16'h0300, 16'h0040, 16'd2, MA_ERR);
    wait_done(dc);
    check("t1_done_latency", done_cyc - t0, 32'd7);
    @(negedge clk);
    check("t1_busy_after", {31'd0, dma_busy}, 32'd0);
    check("t1_writes_left", exp_wr.size(), 32'd0);
    @(posedge clk); #1;

    // Zero-count dump: answered 0, no transfer, no done pulse
    dc = done_count;
    issue(LDUMP, 16'h0300, 16'h0040, 16'd0, 16'd0);
    repeat (6) @(posedge clk);
    #1;
    check("t2_no_done", 32'(done_count - dc), 32'd0);
    check("t2_not_busy", {31'd0, dma_busy}, 32'd0);

    // Fill the pid table, then free and reallocate
    for (int i = 1; i < int'(NPROC); i++) issue(SPAWN, 16'd0, 16'd0, 16'd0, 16'(i));
    issue(SPAWN, 16'd0, 16'd0, 16'd0, MA_ERR);
    issue(FREE,  16'd0, 16'd5, 16'd0, 16'd0);
    issue(SPAWN, 16'd0, 16'd0, 16'd0, 16'd5);

    // Illegal frees leave the table unchanged
    issue(FREE,  16'd0, 16'd0,        16'd0, MA_ERR);
    issue(FREE,  16'd0, 16'(NPROC),   16'd0, MA_ERR);
    issue(FREE,  16'd0, 16'd7,        16'd0, 16'd0);
    issue(FREE,  16'd0, 16'd7,        16'd0, MA_ERR);
    issue(SPAWN, 16'd0, 16'd0,        16'd0, 16'd7);
    issue(SPAWN, 16'd0, 16'd0,        16'd0, MA_ERR);

    // Wrapping LDUMP, with table traffic serviced during the copy
    preload(1'b1, 16'hFFFF, 16'h1111);
    preload(1'b1, 16'h0000, 16'h2222);
    preload(1'b1, 16'h0001, 16'h3333);
    expect_wr(1'b0, 16'hFFFE, 16'h1111);
    expect_wr(1'b0, 16'hFFFF, 16'h2222);
    expect_wr(1'b0, 16'h0000, 16'h3333);
    dc = done_count;
    t0 = cyc;
    issue(LDUMP, 16'hFFFE, 16'hFFFF, 16'd3, 16'd3);
    issue(SPAWN, 16'd0, 16'd0, 16'd0, MA_ERR);
    issue(FREE,  16'd0, 16'd3, 16'd0, 16'd0);
    issue(SPAWN, 16'd0, 16'd0, 16'd0, 16'd3);
    wait_done(dc);
    check("t5_done_latency", done_cyc - t0, 32'd7);
    check("t5_writes_left", exp_wr.size(), 32'd0);

    // Abort a four-word SDUMP during the write of word 2
    preload(1'b0, 16'h0040, 16'h1040);
    preload(1'b0, 16'h0041, 16'h1041);
    preload(1'b0, 16'h0042, 16'h1042);
    preload(1'b0, 16'h0043, 16'h1043);
    expect_wr(1'b1, 16'h0200, 16'h1040);
    dc = done_count;
    issue(SDUMP, 16'h0200, 16'h0040, 16'd4, 16'd4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr = 1'b1;
    @(negedge clk);
    check("t6_we_masked", {30'd0, lm_we, sm_we}, 32'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    check("t6_busy_cleared", {31'd0, dma_busy}, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    check("t6_no_done", 32'(done_count - dc), 32'd0);
    check("t6_writes_left", exp_wr.size(), 32'd0);
    issue(SPAWN, 16'd0, 16'd0, 16'd0, 16'd1);
    issue(SPAWN, 16'd0, 16'd0, 16'd0, 16'd2);
    issue(FREE,  16'd0, 16'd9, 16'd0, MA_ERR);

    @(posedge clk); #1;
    check("answers_left", exp_ans.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
